// File: rtl/axi_lite_read_master.sv
// axi_lite_read_master
//   Single-outstanding AXI4-Lite read master. A command (address) from local
//   control logic is turned into one AR/R transaction; the read data and
//   response code are returned on a buffered response port. A wait-cycle
//   watchdog aborts a transaction whose slave never answers.
//
// Ports
//   ACLK, ARSTn        clock (rising edge), asynchronous active-low reset
//   cmd_valid/ready    command handshake, cmd_addr sampled on handshake
//   rsp_valid/ready    response handshake; rsp_data, rsp_resp, rsp_timeout held
//   rd_count           completed responses (normal and timed out), wraps
//   ARADDER/ARVALID/ARREADY   AXI read-address channel
//   RDATA/RRESP/RVALID/RREADY AXI read-data channel
module axi_lite_read_master #(
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned TIMEOUT = 16
) (
   input  logic              ACLK,
   input  logic              ARSTn,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [ADDR_W-1:0] cmd_addr,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_data,
   output logic [1:0]        rsp_resp,
   output logic              rsp_timeout,
   output logic [15:0]       rd_count,
   output logic [ADDR_W-1:0] ARADDER,
   output logic              ARVALID,
   input  logic              ARREADY,
   input  logic [DATA_W-1:0] RDATA,
   input  logic [1:0]        RRESP,
   input  logic              RVALID,
   output logic              RREADY
);

   // Watchdog counter must hold 0..TIMEOUT; keep one bit when disabled.
   localparam int unsigned     CntW    = (TIMEOUT != 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'((TIMEOUT != 0) ? TIMEOUT - 1 : 0);
   localparam bit              WdEn    = (TIMEOUT != 0);

   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StAddr = 2'd1;
   localparam logic [1:0] StData = 2'd2;
   localparam logic [1:0] StResp = 2'd3;

   logic [1:0]        state_q, state_d;
   logic              cmd_ready_q, cmd_ready_d;
   logic              arvalid_q, arvalid_d;
   logic [ADDR_W-1:0] araddr_q, araddr_d;
   logic              rready_q, rready_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
   logic [1:0]        rsp_resp_q, rsp_resp_d;
   logic              rsp_timeout_q, rsp_timeout_d;
   logic [15:0]       rd_count_q, rd_count_d;
   logic [CntW-1:0]   cnt_q, cnt_d;

   logic ar_hs, r_hs, expire;

   assign ar_hs  = arvalid_q & ARREADY;
   assign r_hs   = rready_q & RVALID;
   assign expire = WdEn && (cnt_q == CntLast);

   always_comb begin
      state_d       = state_q;
      cmd_ready_d   = cmd_ready_q;
      arvalid_d     = arvalid_q;
      araddr_d      = araddr_q;
      rready_d      = rready_q;
      rsp_valid_d   = rsp_valid_q;
      rsp_data_d    = rsp_data_q;
      rsp_resp_d    = rsp_resp_q;
      rsp_timeout_d = rsp_timeout_q;
      rd_count_d    = rd_count_q;
      cnt_d         = cnt_q;

      case (state_q)
         StIdle: begin
            if (cmd_valid && cmd_ready_q) begin
               araddr_d    = cmd_addr;
               arvalid_d   = 1'b1;
               cmd_ready_d = 1'b0;
               cnt_d       = '0;
               state_d     = StAddr;
            end else begin
               cmd_ready_d = 1'b1;
            end
         end
         StAddr: begin
            if (ar_hs) begin
               arvalid_d = 1'b0;
               rready_d  = 1'b1;
               cnt_d     = '0;
               state_d   = StData;
            end else if (expire) begin
               // Hang recovery: drops ARVALID without a handshake.
               arvalid_d     = 1'b0;
               rready_d      = 1'b0;
               rsp_data_d    = '0;
               rsp_resp_d    = 2'b10;
               rsp_timeout_d = 1'b1;
               rsp_valid_d   = 1'b1;
               state_d       = StResp;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         StData: begin
            if (r_hs) begin
               rsp_data_d    = RDATA;
               rsp_resp_d    = RRESP;
               rsp_timeout_d = 1'b0;
               rready_d      = 1'b0;
               rsp_valid_d   = 1'b1;
               state_d       = StResp;
            end else if (expire) begin
               arvalid_d     = 1'b0;
               rready_d      = 1'b0;
               rsp_data_d    = '0;
               rsp_resp_d    = 2'b10;
               rsp_timeout_d = 1'b1;
               rsp_valid_d   = 1'b1;
               state_d       = StResp;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         StResp: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               rd_count_d  = rd_count_q + 16'd1;
               cmd_ready_d = 1'b1;
               state_d     = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge ACLK or negedge ARSTn) begin
      if (!ARSTn) begin
         state_q       <= StIdle;
         cmd_ready_q   <= 1'b0;
         arvalid_q     <= 1'b0;
         araddr_q      <= '0;
         rready_q      <= 1'b0;
         rsp_valid_q   <= 1'b0;
         rsp_data_q    <= '0;
         rsp_resp_q    <= 2'b00;
         rsp_timeout_q <= 1'b0;
         rd_count_q    <= 16'd0;
         cnt_q         <= '0;
      end else begin
         state_q       <= state_d;
         cmd_ready_q   <= cmd_ready_d;
         arvalid_q     <= arvalid_d;
         araddr_q      <= araddr_d;
         rready_q      <= rready_d;
         rsp_valid_q   <= rsp_valid_d;
         rsp_data_q    <= rsp_data_d;
         rsp_resp_q    <= rsp_resp_d;
         rsp_timeout_q <= rsp_timeout_d;
         rd_count_q    <= rd_count_d;
         cnt_q         <= cnt_d;
      end
   end

   assign cmd_ready   = cmd_ready_q;
   assign ARVALID     = arvalid_q;
   assign ARADDER     = araddr_q;
   assign RREADY      = rready_q;
   assign rsp_valid   = rsp_valid_q;
   assign rsp_data    = rsp_data_q;
   assign rsp_resp    = rsp_resp_q;
   assign rsp_timeout = rsp_timeout_q;
   assign rd_count    = rd_count_q;

endmodule

// File: tb/tb_axi_lite_read_master.sv
module tb_axi_lite_read_master;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   always #5 clk = ~clk;

   // DUT with default watchdog (16), driven by a behavioural slave model
   logic        cmd_valid = 1'b0, cmd_ready, rsp_valid, rsp_ready = 1'b1, rsp_timeout;
   logic [31:0] cmd_addr = '0, rsp_data, araddr, rdata;
   logic [1:0]  rsp_resp, rresp;
   logic [15:0] rd_count;
   logic        arvalid, arready, rvalid, rready;

   // DUT with TIMEOUT=4, slave side driven directly by the test
   logic        t_cmd_valid = 1'b0, t_cmd_ready, t_rsp_valid, t_rsp_ready = 1'b0, t_rsp_timeout;
   logic [31:0] t_cmd_addr = '0, t_rsp_data, t_araddr, t_rdata = '0;
   logic [1:0]  t_rsp_resp, t_rresp = 2'b00;
   logic [15:0] t_rd_count;
   logic        t_arvalid, t_arready = 1'b0, t_rvalid = 1'b0, t_rready;

   axi_lite_read_master dut (
      .ACLK(clk), .ARSTn(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout), .rd_count(rd_count),
      .ARADDER(araddr), .ARVALID(arvalid), .ARREADY(arready),
      .RDATA(rdata), .RRESP(rresp), .RVALID(rvalid), .RREADY(rready)
   );

   axi_lite_read_master #(.TIMEOUT(4)) dut_to (
      .ACLK(clk), .ARSTn(rst_n),
      .cmd_valid(t_cmd_valid), .cmd_ready(t_cmd_ready), .cmd_addr(t_cmd_addr),
      .rsp_valid(t_rsp_valid), .rsp_ready(t_rsp_ready), .rsp_data(t_rsp_data),
      .rsp_resp(t_rsp_resp), .rsp_timeout(t_rsp_timeout), .rd_count(t_rd_count),
      .ARADDER(t_araddr), .ARVALID(t_arvalid), .ARREADY(t_arready),
      .RDATA(t_rdata), .RRESP(t_rresp), .RVALID(t_rvalid), .RREADY(t_rready)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Slave model: fixed table 0x10->25, 0x20->50, others 0, unless overridden.
   int          ar_dly = 0, r_dly = 0;
   logic        ov_en = 1'b0;
   logic [31:0] ov_data = '0;
   logic [1:0]  ov_resp = 2'b00;

   function automatic logic [31:0] mem_rd(input logic [31:0] a);
      case (a)
         32'h10:  return 32'd25;
         32'h20:  return 32'd50;
         default: return 32'd0;
      endcase
   endfunction

   initial begin
      int          ph;
      int          cnt;
      logic [31:0] s_addr;
      arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = 2'b00;
      ph = 0; cnt = 0; s_addr = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            ph = 0; cnt = 0; arready = 1'b0; rvalid = 1'b0;
         end else begin
            case (ph)
               0: if (arvalid) begin
                  if (cnt == ar_dly) begin arready = 1'b1; s_addr = araddr; ph = 1; end
                  else cnt++;
               end
               1: begin
                  arready = 1'b0; cnt = 0;
                  if (r_dly == 0) begin
                     rvalid = 1'b1; rdata = ov_en ? ov_data : mem_rd(s_addr);
                     rresp = ov_en ? ov_resp : 2'b00; ph = 2;
                  end else ph = 3;
               end
               3: begin
                  cnt++;
                  if (cnt == r_dly) begin
                     rvalid = 1'b1; rdata = ov_en ? ov_data : mem_rd(s_addr);
                     rresp = ov_en ? ov_resp : 2'b00; ph = 2;
                  end
               end
               default: if (!rready) begin rvalid = 1'b0; ph = 0; cnt = 0; end
            endcase
         end
      end
   end

   // ARVALID rising-edge monitor
   int          arv_pulses = 0;
   logic        arv_prev = 1'b0;
   logic [31:0] ar_seen = '0;
   always @(negedge clk) begin
      arv_prev <= arvalid;
      if (arvalid && !arv_prev) begin
         arv_pulses <= arv_pulses + 1;
         ar_seen    <= araddr;
      end
   end

   task automatic apply_reset();
      @(negedge clk);
      rst_n = 1'b0; cmd_valid = 1'b0; t_cmd_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   // Holds cmd_valid until a handshake edge has passed; returns #1 after it.
   task automatic wait_accept(input string tag);
      bit ok = 0;
      for (int i = 0; i < 30; i++) begin
         if (cmd_ready) begin ok = 1; break; end
         @(negedge clk);
      end
      check(tag, 32'(ok), 32'd1);
      @(posedge clk);
      #1;
   endtask

   task automatic send_cmd(input logic [31:0] a, input string tag);
      @(negedge clk);
      cmd_valid = 1'b1; cmd_addr = a;
      wait_accept(tag);
      cmd_valid = 1'b0;
   endtask

   task automatic wait_rsp(input string tag);
      bit ok = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (rsp_valid) begin ok = 1; break; end
      end
      check(tag, 32'(ok), 32'd1);
   endtask

   initial begin
      int          p0;
      int          hi;
      logic [31:0] d0;
      // Reset values
      #1;
      check("rst_cmd_ready", 32'(cmd_ready), 0);
      check("rst_arvalid", 32'(arvalid), 0);
      check("rst_araddr", araddr, 0);
      check("rst_rready", 32'(rready), 0);
      check("rst_rsp_valid", 32'(rsp_valid), 0);
      check("rst_rsp_data", rsp_data, 0);
      check("rst_rsp_resp", 32'(rsp_resp), 0);
      check("rst_rsp_timeout", 32'(rsp_timeout), 0);
      check("rst_rd_count", 32'(rd_count), 0);
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk);
      check("rst_cmd_ready_after", 32'(cmd_ready), 1);

      // Basic read 0x10 -> 25
      p0 = arv_pulses;
      send_cmd(32'h10, "t1_accept");
      wait_rsp("t1_rsp_wait");
      check("t1_data", rsp_data, 32'd25);
      check("t1_resp", 32'(rsp_resp), 0);
      check("t1_timeout", 32'(rsp_timeout), 0);
      @(negedge clk);
      check("t1_rd_count", 32'(rd_count), 1);
      check("t1_ar_pulses", 32'(arv_pulses - p0), 1);
      check("t1_ar_addr", ar_seen, 32'h10);
      check("t1_cmd_ready", 32'(cmd_ready), 1);

      // Back-to-back with cmd_valid held high
      apply_reset();
      cmd_valid = 1'b1; cmd_addr = 32'h20;
      wait_accept("t2_accept0");
      cmd_addr = 32'h30;
      @(negedge clk);
      check("t2_ready_low", 32'(cmd_ready), 0);
      wait_rsp("t2_rsp0_wait");
      check("t2_data0", rsp_data, 32'd50);
      check("t2_ready_low_rsp", 32'(cmd_ready), 0);
      wait_accept("t2_accept1");
      cmd_valid = 1'b0;
      wait_rsp("t2_rsp1_wait");
      check("t2_data1", rsp_data, 32'd0);
      @(negedge clk);
      check("t2_rd_count", 32'(rd_count), 2);

      // Slow slave with error response
      ar_dly = 5; r_dly = 3; ov_en = 1'b1; ov_data = 32'hDEADBEEF; ov_resp = 2'b10;
      send_cmd(32'h44, "t3_accept");
      for (int i = 0; i < 20 && arvalid; i++) begin
         check("t3_araddr_stable", araddr, 32'h44);
         check("t3_rready_low", 32'(rready), 0);
         @(negedge clk);
      end
      check("t3_ar_done", 32'(arvalid), 0);
      wait_rsp("t3_rsp_wait");
      check("t3_data", rsp_data, 32'hDEADBEEF);
      check("t3_resp", 32'(rsp_resp), 2);
      check("t3_timeout", 32'(rsp_timeout), 0);
      ar_dly = 0; r_dly = 0; ov_en = 1'b0;
      @(negedge clk);

      // Response stalled by rsp_ready low
      apply_reset();
      rsp_ready = 1'b0;
      send_cmd(32'h10, "t4_accept");
      wait_rsp("t4_rsp_wait");
      cmd_valid = 1'b1; cmd_addr = 32'h20;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("t4_rsp_valid", 32'(rsp_valid), 1);
         check("t4_rsp_data", rsp_data, 32'd25);
         check("t4_cmd_ready", 32'(cmd_ready), 0);
         check("t4_arvalid", 32'(arvalid), 0);
      end
      cmd_valid = 1'b0; rsp_ready = 1'b1;
      @(negedge clk);
      check("t4_released", 32'(rsp_valid), 0);
      check("t4_rd_count", 32'(rd_count), 1);

      // Watchdog TIMEOUT=4, ARREADY never asserted
      @(negedge clk);
      check("t5_cmd_ready", 32'(t_cmd_ready), 1);
      t_cmd_valid = 1'b1; t_cmd_addr = 32'h50;
      @(posedge clk); #1 t_cmd_valid = 1'b0;
      hi = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (t_rsp_valid) break;
         if (t_arvalid) hi++;
      end
      check("t5_ar_cycles", 32'(hi), 4);
      check("t5_rsp_valid", 32'(t_rsp_valid), 1);
      check("t5_resp", 32'(t_rsp_resp), 2);
      check("t5_timeout", 32'(t_rsp_timeout), 1);
      check("t5_data", t_rsp_data, 0);
      check("t5_arvalid", 32'(t_arvalid), 0);
      t_rsp_ready = 1'b1;
      @(negedge clk);
      check("t5_rd_count", 32'(t_rd_count), 1);
      check("t5_cmd_ready_back", 32'(t_cmd_ready), 1);

      // ARREADY arriving on the 4th cycle wins over the abort
      t_cmd_valid = 1'b1; t_cmd_addr = 32'h54;
      @(posedge clk); #1 t_cmd_valid = 1'b0;
      hi = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (t_arvalid) hi++;
         if (hi == 4) break;
      end
      t_arready = 1'b1;
      @(negedge clk);
      t_arready = 1'b0;
      check("t5b_arvalid", 32'(t_arvalid), 0);
      check("t5b_no_abort", 32'(t_rsp_valid), 0);
      check("t5b_rready", 32'(t_rready), 1);
      t_rvalid = 1'b1; t_rdata = 32'h1234; t_rresp = 2'b00;
      @(negedge clk);
      t_rvalid = 1'b0;
      check("t5b_rsp_valid", 32'(t_rsp_valid), 1);
      check("t5b_data", t_rsp_data, 32'h1234);
      check("t5b_timeout", 32'(t_rsp_timeout), 0);
      check("t5b_resp", 32'(t_rsp_resp), 0);
      @(negedge clk);
      check("t5b_rd_count", 32'(t_rd_count), 2);

      // Asynchronous reset while in DATA
      r_dly = 20;
      send_cmd(32'h20, "t6_accept");
      hi = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (rready) begin hi = 1; break; end
      end
      check("t6_in_data", 32'(hi), 1);
      #2 rst_n = 1'b0;
      #1;
      check("t6_rready", 32'(rready), 0);
      check("t6_cmd_ready", 32'(cmd_ready), 0);
      check("t6_arvalid", 32'(arvalid), 0);
      check("t6_araddr", araddr, 0);
      check("t6_rsp_valid", 32'(rsp_valid), 0);
      check("t6_rd_count", 32'(rd_count), 0);
      @(negedge clk);
      r_dly = 0;
      rst_n = 1'b1;
      @(negedge clk);
      check("t6_cmd_ready_after", 32'(cmd_ready), 1);
      send_cmd(32'h10, "t6_accept2");
      wait_rsp("t6_rsp_wait");
      d0 = rsp_data;
      check("t6_data", d0, 32'd25);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
